// File: rtl/wb_hazard_scoreboard_if.sv
// Pipeline-side signals of the hazard scoreboard: ID operands, EX flush, WB commit,
// and the stall/issue decision returned to the ID stage.
interface wb_hazard_scoreboard_if #(
  parameter int AW = 3
);
  logic          id_valid;
  logic          id_regwrite;
  logic [AW-1:0] id_rd;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic          ex_flush;
  logic          ex_regwrite;
  logic [AW-1:0] ex_rd;
  logic          wb_regwrite;
  logic [AW-1:0] wb_rd;
  logic          stall;
  logic          issue;

  modport master (
    output id_valid, id_regwrite, id_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_flush, ex_regwrite, ex_rd, wb_regwrite, wb_rd,
    input  stall, issue
  );

  modport slave (
    input  id_valid, id_regwrite, id_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_flush, ex_regwrite, ex_rd, wb_regwrite, wb_rd,
    output stall, issue
  );
endinterface

// File: rtl/wb_hazard_scoreboard.sv
// Register scoreboard for the ID/EX/WB pipeline: counts pending writes per register,
// stalls ID on a RAW hazard, and keeps saturating stall statistics and sticky error flags.
module wb_hazard_scoreboard #(
  parameter int NREGS  = 8,
  parameter int AW     = 3,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_hazard_scoreboard_if.slave bus,
  output logic [NREGS-1:0]      busy_mask,
  output logic [STAT_W-1:0]     stall_count,
  output logic                  err_underflow,
  output logic                  err_overflow
);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] cnt     [NREGS];
  logic [CNT_W-1:0] cnt_nxt [NREGS];
  logic [NREGS-1:0] inc_vec;
  logic [NREGS-1:0] dec_wb_vec;
  logic [NREGS-1:0] dec_fl_vec;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             stall_int;
  logic             issue_int;
  logic             under_hit;
  logic             over_hit;
  int               net;

  // The hazard check reads the current counters, so rd == rs with nothing pending still issues.
  assign rs1_hit   = bus.id_rs1_used && (cnt[bus.id_rs1] != '0);
  assign rs2_hit   = bus.id_rs2_used && (cnt[bus.id_rs2] != '0);
  assign stall_int = bus.id_valid && (rs1_hit || rs2_hit);
  assign issue_int = bus.id_valid && !stall_int;
  assign bus.stall = stall_int;
  assign bus.issue = issue_int;

  assign inc_vec    = (issue_int && bus.id_regwrite)       ? (NREGS'(1) << bus.id_rd) : '0;
  assign dec_wb_vec = bus.wb_regwrite                      ? (NREGS'(1) << bus.wb_rd) : '0;
  assign dec_fl_vec = (bus.ex_flush && bus.ex_regwrite)    ? (NREGS'(1) << bus.ex_rd) : '0;

  // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    under_hit = 1'b0;
    over_hit  = 1'b0;
    net       = 0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt[r] = cnt[r];
      net = int'(cnt[r]) + int'(inc_vec[r]) - int'(dec_wb_vec[r]) - int'(dec_fl_vec[r]);
      if (net < 0) begin
        cnt_nxt[r] = '0;
        under_hit  = 1'b1;
      end else if (net > CNT_MAX) begin
        cnt_nxt[r] = CNT_W'(CNT_MAX);
        over_hit   = 1'b1;
      end else begin
        cnt_nxt[r] = CNT_W'(net);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the counter array is reset explicitly; a stale pending count would otherwise stall ID indefinitely.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
      busy_mask     <= '0;
      stall_count   <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r]       <= cnt_nxt[r];
        busy_mask[r] <= (cnt_nxt[r] != '0);
      end
      if (stall_int && (stall_count != '1)) begin
        stall_count <= stall_count + STAT_W'(1);
      end
      err_underflow <= err_underflow | under_hit;
      err_overflow  <= err_overflow  | over_hit;
    end
  end
endmodule

// File: tb/tb_wb_hazard_scoreboard.sv
// Self-checking bench for wb_hazard_scoreboard: directed hazard scenarios plus a randomized
// pipeline, all compared against a per-register pending-write count model.
module tb_wb_hazard_scoreboard;
  localparam int NREGS  = 8;
  localparam int AW     = 3;
  localparam int CNT_W  = 2;
  localparam int STAT_W = 16;
  localparam int SAT_W  = 6;
  localparam int CMAX   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_hazard_scoreboard_if #(.AW(AW)) bus ();
  wb_hazard_scoreboard_if #(.AW(AW)) sat_bus ();

  logic [NREGS-1:0]  busy_mask;
  logic [STAT_W-1:0] stall_count;
  logic              err_underflow;
  logic              err_overflow;
  logic [NREGS-1:0]  sat_busy;
  logic [SAT_W-1:0]  sat_count;
  logic              sat_uf;
  logic              sat_of;

  wb_hazard_scoreboard #(.NREGS(NREGS), .AW(AW), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_mask(busy_mask), .stall_count(stall_count),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  // Narrow statistics counter so saturation is also exercised at a small width.
  wb_hazard_scoreboard #(.NREGS(NREGS), .AW(AW), .CNT_W(CNT_W), .STAT_W(SAT_W)) sat_dut (
    .clk(clk), .rst(rst), .bus(sat_bus), .busy_mask(sat_busy), .stall_count(sat_count),
    .err_underflow(sat_uf), .err_overflow(sat_of)
  );

  assign sat_bus.id_valid    = bus.id_valid;
  assign sat_bus.id_regwrite = bus.id_regwrite;
  assign sat_bus.id_rd       = bus.id_rd;
  assign sat_bus.id_rs1      = bus.id_rs1;
  assign sat_bus.id_rs2      = bus.id_rs2;
  assign sat_bus.id_rs1_used = bus.id_rs1_used;
  assign sat_bus.id_rs2_used = bus.id_rs2_used;
  assign sat_bus.ex_flush    = bus.ex_flush;
  assign sat_bus.ex_regwrite = bus.ex_regwrite;
  assign sat_bus.ex_rd       = bus.ex_rd;
  assign sat_bus.wb_regwrite = bus.wb_regwrite;
  assign sat_bus.wb_rd       = bus.wb_rd;

  typedef struct packed {
    logic          v;
    logic          w;
    logic [AW-1:0] rd;
  } slot_t;

  slot_t         ex_s, wb_s;
  logic          id_v, id_w, id_u1, id_u2;
  logic [AW-1:0] id_rd, id_rs1, id_rs2;
  logic          man, man_wb, man_fl;
  logic [AW-1:0] man_wb_rd, man_fl_rd;
  logic          flush_req, chk_comb, last_issue, obs_issue;

  int     cnt_m [NREGS];
  longint stalls_m;
  logic   uf_m, of_m;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.id_valid    = id_v;
    bus.id_regwrite = id_w;
    bus.id_rd       = id_rd;
    bus.id_rs1      = id_rs1;
    bus.id_rs2      = id_rs2;
    bus.id_rs1_used = id_u1;
    bus.id_rs2_used = id_u2;
    bus.ex_flush    = man ? man_fl    : (flush_req & ex_s.v);
    bus.ex_regwrite = man ? man_fl    : ex_s.w;
    bus.ex_rd       = man ? man_fl_rd : ex_s.rd;
    bus.wb_regwrite = man ? man_wb    : (wb_s.v & wb_s.w);
    bus.wb_rd       = man ? man_wb_rd : wb_s.rd;
  endtask

  // One clock: drive, check combinational outputs mid-cycle, advance model and pipeline, check state.
  task automatic tick();
    logic             exp_stall, exp_issue, d_wb, d_fl;
    logic [AW-1:0]    wb_r, fl_r;
    logic [NREGS-1:0] exp_busy;
    logic [31:0]      exp_sc, exp_sat;
    int               net;
    drive();
    d_fl = bus.ex_flush & bus.ex_regwrite;
    fl_r = bus.ex_rd;
    d_wb = bus.wb_regwrite;
    wb_r = bus.wb_rd;
    exp_stall = id_v && ((id_u1 && cnt_m[id_rs1] > 0) || (id_u2 && cnt_m[id_rs2] > 0));
    exp_issue = id_v && !exp_stall;
    #1;
    obs_issue = bus.issue;
    if (chk_comb) begin
      check("stall", 32'(bus.stall), 32'(exp_stall));
      check("issue", 32'(bus.issue), 32'(exp_issue));
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) cnt_m[r] = 0;
      stalls_m = 0;
      uf_m     = 1'b0;
      of_m     = 1'b0;
    end else begin
      if (exp_stall) stalls_m++;
      for (int r = 0; r < NREGS; r++) begin
        net = cnt_m[r];
        if (exp_issue && id_w && id_rd == AW'(r)) net = net + 1;
        if (d_wb && wb_r == AW'(r)) net = net - 1;
        if (d_fl && fl_r == AW'(r)) net = net - 1;
        if (net < 0) begin
          net  = 0;
          uf_m = 1'b1;
        end else if (net > CMAX) begin
          net  = CMAX;
          of_m = 1'b1;
        end
        cnt_m[r] = net;
      end
    end
    wb_s       = d_fl ? '0 : ex_s;
    ex_s       = exp_issue ? '{v: 1'b1, w: id_w, rd: id_rd} : '0;
    last_issue = exp_issue;
    #1;
    for (int r = 0; r < NREGS; r++) exp_busy[r] = (cnt_m[r] != 0);
    exp_sc  = (stalls_m > 65535) ? 32'd65535 : 32'(stalls_m);
    exp_sat = (stalls_m > 63)    ? 32'd63    : 32'(stalls_m);
    check("busy_mask",     32'(busy_mask),     32'(exp_busy));
    check("stall_count",   32'(stall_count),   exp_sc);
    check("err_underflow", 32'(err_underflow), 32'(uf_m));
    check("err_overflow",  32'(err_overflow),  32'(of_m));
    check("sat_count",     32'(sat_count),     exp_sat);
    check("sat_busy",      32'(sat_busy),      32'(exp_busy));
  endtask

  task automatic idle(input int n);
    id_v      = 1'b0;
    flush_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic run_instr(input logic w, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                           input logic u1, input logic [AW-1:0] rs2, input logic u2,
                           input logic rnd_flush, output int nst);
    id_v   = 1'b1;
    id_w   = w;
    id_rd  = rd;
    id_rs1 = rs1;
    id_u1  = u1;
    id_rs2 = rs2;
    id_u2  = u2;
    nst    = 0;
    for (int k = 0; k < 20; k++) begin
      flush_req = rnd_flush ? ($urandom_range(0, 9) == 0) : 1'b0;
      tick();
      if (last_issue) break;
      nst++;
    end
    check("issued", 32'(last_issue), 32'd1);
    id_v      = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    man = 1'b1;
    repeat (2) begin
      id_v      = 1'($urandom_range(0, 1));
      id_w      = 1'($urandom_range(0, 1));
      id_rd     = AW'($urandom_range(0, NREGS - 1));
      id_rs1    = AW'($urandom_range(0, NREGS - 1));
      id_rs2    = AW'($urandom_range(0, NREGS - 1));
      id_u1     = 1'($urandom_range(0, 1));
      id_u2     = 1'($urandom_range(0, 1));
      man_wb    = 1'($urandom_range(0, 1));
      man_fl    = 1'($urandom_range(0, 1));
      man_wb_rd = AW'($urandom_range(0, NREGS - 1));
      man_fl_rd = AW'($urandom_range(0, NREGS - 1));
      tick();
    end
    rst       = 1'b0;
    man       = 1'b0;
    man_wb    = 1'b0;
    man_fl    = 1'b0;
    id_v      = 1'b0;
    flush_req = 1'b0;
    ex_s      = '0;
    wb_s      = '0;
  endtask

  initial begin
    int nst;
    rst = 1'b1; chk_comb = 1'b0; ex_s = '0; wb_s = '0; flush_req = 1'b0;
    id_v = 1'b0; id_w = 1'b0; id_u1 = 1'b0; id_u2 = 1'b0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    man = 1'b0; man_wb = 1'b0; man_fl = 1'b0; man_wb_rd = '0; man_fl_rd = '0;
    last_issue = 1'b0; obs_issue = 1'b0;
    for (int r = 0; r < NREGS; r++) cnt_m[r] = 0;
    stalls_m = 0; uf_m = 1'b0; of_m = 1'b0;

    // Reset with random inputs; combinational checks start once counters are defined.
    do_reset();
    chk_comb = 1'b1;
    check("rst_busy",  32'(busy_mask),     32'd0);
    check("rst_count", 32'(stall_count),   32'd0);
    check("rst_uf",    32'(err_underflow), 32'd0);
    check("rst_of",    32'(err_overflow),  32'd0);
    for (int i = 0; i < 4; i++) begin
      id_v = 1'b1; id_w = 1'b0; id_u1 = 1'b1; id_u2 = 1'b1;
      id_rs1 = AW'($urandom_range(0, NREGS - 1));
      id_rs2 = AW'($urandom_range(0, NREGS - 1));
      drive();
      #1;
      check("rst_stall", 32'(bus.stall), 32'd0);
      tick();
    end
    idle(1);

    // RAW distance 0 / 1 / 2 on r3, rs2 path and a self-dependent instruction.
    do_reset();
    run_instr(1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, nst);
    check("raw_busy_set", 32'(busy_mask[3]), 32'd1);
    run_instr(1'b0, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, nst);
    check("raw_d0_stalls",   32'(nst),          32'd2);
    check("raw_busy_clear",  32'(busy_mask[3]), 32'd0);
    check("raw_stall_count", 32'(stall_count),  32'd2);
    idle(3);
    run_instr(1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, nst);
    run_instr(1'b0, 3'd0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, nst);
    run_instr(1'b0, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, nst);
    check("raw_d1_stalls", 32'(nst), 32'd1);
    idle(3);
    run_instr(1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, nst);
    run_instr(1'b0, 3'd0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, nst);
    run_instr(1'b0, 3'd0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, nst);
    run_instr(1'b0, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, nst);
    check("raw_d2_stalls", 32'(nst), 32'd0);
    idle(3);
    run_instr(1'b1, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, nst);
    run_instr(1'b0, 3'd0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, nst);
    check("raw_rs2_stalls", 32'(nst), 32'd2);
    idle(3);
    run_instr(1'b1, 3'd6, 3'd6, 1'b1, 3'd6, 1'b1, 1'b0, nst);
    check("self_dep_stalls", 32'(nst), 32'd0);
    idle(3);

    // WAW on r5, then flush one copy and commit the other; a reader waits for both.
    do_reset();
    man = 1'b1;
    id_v = 1'b1; id_w = 1'b1; id_rd = 3'd5; id_u1 = 1'b0; id_u2 = 1'b0;
    tick();
    tick();
    check("waw_busy_two", 32'(busy_mask[5]), 32'd1);
    id_w = 1'b0; id_rs1 = 3'd5; id_u1 = 1'b1;
    man_fl = 1'b1; man_fl_rd = 3'd5;
    tick();
    man_fl = 1'b0;
    check("waw_flush_stall", 32'(obs_issue),    32'd0);
    check("waw_busy_one",    32'(busy_mask[5]), 32'd1);
    man_wb = 1'b1; man_wb_rd = 3'd5;
    tick();
    man_wb = 1'b0;
    check("waw_wb_stall",  32'(obs_issue),    32'd0);
    check("waw_busy_zero", 32'(busy_mask[5]), 32'd0);
    tick();
    check("waw_reader_issue", 32'(obs_issue), 32'd1);
    idle(1);

    // Same-cycle increment and decrement on r2.
    do_reset();
    man = 1'b1;
    id_v = 1'b1; id_w = 1'b1; id_rd = 3'd2; id_u1 = 1'b0; id_u2 = 1'b0;
    tick();
    man_wb = 1'b1; man_wb_rd = 3'd2;
    tick();
    check("simul_busy_kept", 32'(busy_mask[2]), 32'd1);
    id_v = 1'b0;
    tick();
    man_wb = 1'b0;
    check("simul_busy_drained", 32'(busy_mask[2]), 32'd0);

    // Underflow on r7, then overflow on r1 (counter clamps at 3).
    do_reset();
    man = 1'b1; id_v = 1'b0;
    man_wb = 1'b1; man_wb_rd = 3'd7;
    tick();
    man_wb = 1'b0;
    check("uf_flag",  32'(err_underflow), 32'd1);
    check("uf_busy7", 32'(busy_mask[7]),  32'd0);
    check("uf_no_of", 32'(err_overflow),  32'd0);
    id_v = 1'b1; id_w = 1'b1; id_rd = 3'd1; id_u1 = 1'b0; id_u2 = 1'b0;
    repeat (4) tick();
    id_v = 1'b0;
    check("of_flag", 32'(err_overflow), 32'd1);
    man_wb = 1'b1; man_wb_rd = 3'd1;
    tick();
    tick();
    check("of_busy_after2", 32'(busy_mask[1]), 32'd1);
    tick();
    check("of_busy_after3", 32'(busy_mask[1]), 32'd0);
    man_wb = 1'b0;
    tick();
    check("uf_sticky", 32'(err_underflow), 32'd1);
    check("of_sticky", 32'(err_overflow),  32'd1);

    // Long stall: both statistics counters must saturate.
    do_reset();
    man = 1'b1;
    id_v = 1'b1; id_w = 1'b1; id_rd = 3'd4; id_u1 = 1'b0; id_u2 = 1'b0;
    tick();
    id_w = 1'b0; id_rs1 = 3'd4; id_u1 = 1'b1;
    repeat (65600) tick();
    check("sat_16bit", 32'(stall_count), 32'hFFFF);
    check("sat_6bit",  32'(sat_count),   32'd63);
    idle(1);

    // Randomized pipeline traffic with occasional EX flushes.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      run_instr(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS - 1)),
                AW'($urandom_range(0, NREGS - 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, NREGS - 1)), 1'($urandom_range(0, 1)), 1'b1, nst);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
